i2s_sample_sched: RTL

I2S_SAMPLE_SCHED -- requirements
Module: i2s_sample_sched

---
 rtl/i2s_sample_sched_pkg.sv | 21 ++
 rtl/i2s_sample_sched_fifo.sv | 39 +++
 rtl/i2s_sample_sched.sv | 111 +++++++++++
 3 files changed

// File: rtl/i2s_sample_sched_pkg.sv
// i2s_sample_sched_pkg: source modes, frame FSM states and stereo sample container
package i2s_sample_sched_pkg;
  typedef enum logic [1:0] {
    MODE_SRC0 = 2'd0,
    MODE_SRC1 = 2'd1,
    MODE_MIX  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_MIX,
    S_STROBE
  } state_e;
  localparam int SAMPLE_WIDTH_MAX = 32;
  // Widest supported stereo sample; narrower samples occupy the low bits.
  typedef struct packed {
    logic [SAMPLE_WIDTH_MAX-1:0] left;
    logic [SAMPLE_WIDTH_MAX-1:0] right;
  } stereo_t;
endpackage

// File: rtl/i2s_sample_sched_fifo.sv
// sample_fifo: synchronous FIFO with fall-through head; push is refused while full
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/i2s_sample_sched.sv
// i2s_sample_sched: per-frame sample scheduler feeding an I2S transmitter from two FIFO'd sources.
// Define I2S_SAMPLE_SCHED_MIX_EN to build the saturating MIX mode; otherwise mode 2 plays SRC0.
module i2s_sample_sched
  import i2s_sample_sched_pkg::*;
#(
  parameter int  SAMPLE_WIDTH = 16,
  parameter real CLK_FREQ     = 12.288e6,
  parameter real SAMPLE_FREQ  = 48e3,
  parameter int  FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    src0_valid,
  input  logic                    src1_valid,
  input  logic [SAMPLE_WIDTH-1:0] src0_left,
  input  logic [SAMPLE_WIDTH-1:0] src0_right,
  input  logic [SAMPLE_WIDTH-1:0] src1_left,
  input  logic [SAMPLE_WIDTH-1:0] src1_right,
  output logic                    src0_ready,
  output logic                    src1_ready,
  output logic [SAMPLE_WIDTH-1:0] left_channel,
  output logic [SAMPLE_WIDTH-1:0] right_channel,
  output logic                    sample_clk_en,
  output logic                    underrun,
  output logic [7:0]              underrun_count
);
  localparam int SW = SAMPLE_WIDTH;
  localparam int TICK_DIV = $rtoi(CLK_FREQ / SAMPLE_FREQ);
  localparam int CW = $clog2(TICK_DIV);
  state_e state, state_nx;
  mode_e sel, sel_q;
  logic [CW-1:0] cnt;
  logic tick, in_fetch, in_mix, ok, ur_q, live;
  logic pop0, pop1, full0, full1, empty0, empty1;
  logic [2*SW-1:0] head0, head1, snap0, snap1;
  logic [SW-1:0] mix_l, mix_r;
  assign tick = cnt == CW'(TICK_DIV - 1);
  assign src0_ready = live && !full0;
  assign src1_ready = live && !full1;
`ifdef I2S_SAMPLE_SCHED_MIX_EN
  assign sel = mode == 2'd1 ? MODE_SRC1 : mode == 2'd2 ? MODE_MIX : MODE_SRC0;
  function automatic logic [SW-1:0] sat_add(logic [SW-1:0] a, logic [SW-1:0] b);
    logic [SW:0] s;
    s = {a[SW-1], a} + {b[SW-1], b};
    return (s[SW] ^ s[SW-1]) ? {s[SW], {(SW-1){~s[SW]}}} : s[SW-1:0];
  endfunction
  assign mix_l = sel_q == MODE_SRC1 ? snap1[2*SW-1:SW] :
                 sel_q == MODE_MIX  ? sat_add(snap0[2*SW-1:SW], snap1[2*SW-1:SW]) : snap0[2*SW-1:SW];
  assign mix_r = sel_q == MODE_SRC1 ? snap1[SW-1:0] :
                 sel_q == MODE_MIX  ? sat_add(snap0[SW-1:0], snap1[SW-1:0]) : snap0[SW-1:0];
`else
  assign sel = mode == 2'd1 ? MODE_SRC1 : MODE_SRC0;
  assign mix_l = sel_q == MODE_SRC1 ? snap1[2*SW-1:SW] : snap0[2*SW-1:SW];
  assign mix_r = sel_q == MODE_SRC1 ? snap1[SW-1:0] : snap0[SW-1:0];
`endif
  // A frame proceeds only if every source the mode needs has data.
  assign ok = !((sel != MODE_SRC1 && empty0) || (sel != MODE_SRC0 && empty1));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == S_IDLE  ? (tick ? S_FETCH : S_IDLE) :
               state == S_FETCH ? S_MIX :
               state == S_MIX   ? S_STROBE : S_IDLE;
  end
  always_comb begin
    in_fetch = state == S_FETCH;
    in_mix = state == S_MIX;
    sample_clk_en = state == S_STROBE;
    underrun = sample_clk_en && ur_q;
    pop0 = in_fetch && ok && !empty0;
    pop1 = in_fetch && ok && !empty1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      live <= 1'b0;
      sel_q <= MODE_SRC0;
      ur_q <= 1'b0;
      snap0 <= '0;
      snap1 <= '0;
      left_channel <= '0;
      right_channel <= '0;
      underrun_count <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      live <= 1'b1;
      if (in_fetch) begin
        sel_q <= sel;
        ur_q <= !ok;
        snap0 <= head0;
        snap1 <= head1;
      end
      if (in_mix && !ur_q) begin
        left_channel <= mix_l;
        right_channel <= mix_r;
      end
      if (underrun && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
    end
  end
  sample_fifo #(.WIDTH(2*SW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .push(src0_valid && src0_ready), .pop(pop0),
    .din({src0_left, src0_right}), .full(full0), .empty(empty0), .head(head0)
  );
  sample_fifo #(.WIDTH(2*SW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .push(src1_valid && src1_ready), .pop(pop1),
    .din({src1_left, src1_right}), .full(full1), .empty(empty1), .head(head1)
  );
endmodule
